// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the front-panel button debouncer.
// Latency: none (types and constants only).
// Backpressure: none.
package button_debouncer_pkg;

    // Per-channel debounce FSM state codes.
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_PEND = 2'd1,
        ST_PRESSED    = 2'd2,
        ST_REL_PEND   = 2'd3
    } btn_state_e;

    // Default tick constants at a 100 Hz sampling tick.
    localparam int DEF_NUM_BTN      = 5;
    localparam int DEF_STABLE_TICKS = 3;    // 30 ms
    localparam int DEF_HOLD_TICKS   = 100;  // 1 s

endpackage

// File: rtl/button_debouncer_channel.sv
// One button channel: 2-FF synchroniser, debounce FSM, hold counter, registered pulses.
// Latency: 2 clk_in to sync, outputs update the cycle after the STABLE_TICKS-th agreeing tick.
// Backpressure: none; pulses are one-cycle and must be consumed when they appear.
//
// Ports: clk_in/rst_n clock and async active-low reset; tick_100hz sampling enable;
//        btn_raw asynchronous raw button; btn_level/btn_press/btn_release/btn_long outputs.
module debounce_channel
    import button_debouncer_pkg::*;
#(
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int HOLD_TICKS   = DEF_HOLD_TICKS
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic tick_100hz,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);

    localparam int SCNT_W = $clog2(STABLE_TICKS + 1);
    localparam int HCNT_W = $clog2(HOLD_TICKS + 1);
    localparam logic [SCNT_W-1:0] STABLE_C = SCNT_W'(STABLE_TICKS);
    localparam logic [HCNT_W-1:0] HOLD_C   = HCNT_W'(HOLD_TICKS);

    logic              sync1_q, sync2_q;
    btn_state_e        state_q, state_d;
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;

    logic [SCNT_W-1:0] scnt_inc;
    logic [HCNT_W-1:0] hcnt_inc;

    assign scnt_inc = scnt_q + SCNT_W'(1);
    assign hcnt_inc = hcnt_q + HCNT_W'(1);

    always_comb begin
        state_d   = state_q;
        scnt_d    = scnt_q;
        hcnt_d    = hcnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        if (tick_100hz) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (sync2_q) begin
                        state_d = ST_PRESS_PEND;
                        scnt_d  = SCNT_W'(1);
                    end
                end
                ST_PRESS_PEND: begin
                    if (!sync2_q) begin
                        state_d = ST_IDLE;
                        scnt_d  = '0;
                    end else if (scnt_inc == STABLE_C) begin
                        state_d = ST_PRESSED;
                        scnt_d  = '0;
                        hcnt_d  = '0;
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        scnt_d = scnt_inc;
                    end
                end
                ST_PRESSED: begin
                    if (!sync2_q) begin
                        state_d = ST_REL_PEND;
                        scnt_d  = SCNT_W'(1);
                    end else if (hcnt_q != HOLD_C) begin
                        // Saturation at HOLD_C makes the long pulse fire once per press.
                        hcnt_d = hcnt_inc;
                        long_d = (hcnt_inc == HOLD_C);
                    end
                end
                ST_REL_PEND: begin
                    if (sync2_q) begin
                        // Release glitch: resume the hold where it left off.
                        state_d = ST_PRESSED;
                        scnt_d  = '0;
                    end else if (scnt_inc == STABLE_C) begin
                        state_d   = ST_IDLE;
                        scnt_d    = '0;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        scnt_d = scnt_inc;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            state_q   <= ST_IDLE;
            scnt_q    <= '0;
            hcnt_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            scnt_q    <= scnt_d;
            hcnt_q    <= hcnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_long    = long_q;

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel push-button conditioner: NUM_BTN independent debounce channels.
// Latency: 2 clk_in sync plus STABLE_TICKS ticks, outputs registered.
// Backpressure: none; level and one-cycle pulses are presented unconditionally.
//
// Ports: clk_in/rst_n clock and async active-low reset; tick_100hz sampling strobe;
//        btn_raw[NUM_BTN] raw buttons; btn_level/press/release/long[NUM_BTN] outputs.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int NUM_BTN      = DEF_NUM_BTN,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int HOLD_TICKS   = DEF_HOLD_TICKS
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic               tick_100hz,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_long
);

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
        debounce_channel #(
            .STABLE_TICKS (STABLE_TICKS),
            .HOLD_TICKS   (HOLD_TICKS)
        ) u_chan (
            .clk_in      (clk_in),
            .rst_n       (rst_n),
            .tick_100hz  (tick_100hz),
            .btn_raw     (btn_raw[g]),
            .btn_level   (btn_level[g]),
            .btn_press   (btn_press[g]),
            .btn_release (btn_release[g]),
            .btn_long    (btn_long[g])
        );
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed scenarios plus random button activity,
// every cycle compared against a run-length reference model.
// Tick is one strobe every 10 clk_in cycles, STABLE_TICKS=3, HOLD_TICKS=8.
module tb_button_debouncer;

    localparam int NB     = 5;
    localparam int STABLE = 3;
    localparam int HOLD   = 8;

    logic          clk_in = 1'b0;
    logic          rst_n  = 1'b0;
    logic          tick_100hz = 1'b0;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] btn_level, btn_press, btn_release, btn_long;

    button_debouncer #(
        .NUM_BTN      (NB),
        .STABLE_TICKS (STABLE),
        .HOLD_TICKS   (HOLD)
    ) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .tick_100hz  (tick_100hz),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long)
    );

    always #5 clk_in = ~clk_in;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Reference model: a button's level flips after STABLE consecutive ticks that
    // disagree with it; hold time counts ticks seen high while pressed and not in a
    // pending release.
    logic [NB-1:0] m_s1, m_s2;
    logic [NB-1:0] m_level, m_press, m_release, m_long;
    int            m_run  [NB];
    int            m_held [NB];
    int            cnt_press [NB];
    int            cnt_rel   [NB];
    int            cnt_long  [NB];

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0;
        m_level = '0; m_press = '0; m_release = '0; m_long = '0;
        for (int i = 0; i < NB; i++) begin
            m_run[i]  = 0;
            m_held[i] = 0;
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < NB; i++) begin
            cnt_press[i] = 0; cnt_rel[i] = 0; cnt_long[i] = 0;
        end
    endtask

    task automatic model_edge();
        logic samp;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_press = '0; m_release = '0; m_long = '0;
        if (tick_100hz) begin
            for (int i = 0; i < NB; i++) begin
                samp = m_s2[i];
                if (samp != m_level[i]) begin
                    m_run[i]++;
                    if (m_run[i] == STABLE) begin
                        m_run[i] = 0;
                        m_level[i] = samp;
                        if (samp) begin
                            m_press[i] = 1'b1;
                            m_held[i]  = 0;
                        end else begin
                            m_release[i] = 1'b1;
                        end
                    end
                end else begin
                    if (m_level[i] && m_run[i] == 0 && m_held[i] < HOLD) begin
                        m_held[i]++;
                        if (m_held[i] == HOLD) m_long[i] = 1'b1;
                    end
                    m_run[i] = 0;
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = btn_raw;
    endtask

    // One clk_in cycle: drive tick, take the edge, update model, compare after the edge.
    task automatic step();
        tick_100hz = (cyc % 10 == 9);
        @(posedge clk_in);
        model_edge();
        #1;
        chk("level",   btn_level,   m_level);
        chk("press",   btn_press,   m_press);
        chk("release", btn_release, m_release);
        chk("long",    btn_long,    m_long);
        for (int i = 0; i < NB; i++) begin
            cnt_press[i] += int'(btn_press[i]);
            cnt_rel[i]   += int'(btn_release[i]);
            cnt_long[i]  += int'(btn_long[i]);
        end
        cyc++;
    endtask

    task automatic run_ticks(input int n);
        repeat (n * 10) step();
    endtask

    // Reset asserted between edges; level must drop before the next clock edge.
    task automatic async_reset(input string tag);
        #3;
        rst_n = 1'b0;
        #1;
        chk({tag, "_lvl"}, btn_level, 0);
        chk({tag, "_rel"}, btn_release, 0);
        model_reset();
        repeat (10) step();
        rst_n = 1'b1;
    endtask

    int total;

    initial begin
        model_reset();
        clear_counts();

        // 1: reset with all buttons held
        btn_raw = 5'b11111;
        #1;
        chk("rst_level", btn_level, 0);
        chk("rst_pulses", {btn_press, btn_release, btn_long}, 0);
        repeat (10) step();
        rst_n = 1'b1;
        clear_counts();
        run_ticks(5);
        total = 0;
        for (int i = 0; i < NB; i++) total += (cnt_press[i] == 1) ? 1 : 0;
        chk("rst_one_press_each", total, NB);
        chk("rst_level_up", btn_level, 5'b11111);
        btn_raw = '0;
        run_ticks(5);
        chk("rst_all_released", btn_level, 0);

        // 2: clean press on bit 0
        clear_counts();
        btn_raw = 5'b00001;
        run_ticks(5);
        chk("clean_press0", cnt_press[0], 1);
        chk("clean_others", cnt_press[1] + cnt_press[2] + cnt_press[3] + cnt_press[4], 0);
        btn_raw = '0;
        run_ticks(5);

        // 3: press bounce on bit 1
        clear_counts();
        for (int k = 0; k < 4; k++) begin
            btn_raw[1] = (k % 2 == 0);
            run_ticks(1);
        end
        chk("bounce_no_press", cnt_press[1], 0);
        btn_raw[1] = 1'b1;
        run_ticks(3);
        chk("bounce_then_press", cnt_press[1], 1);
        btn_raw = '0;
        run_ticks(5);

        // 4: long press on bit 2
        clear_counts();
        btn_raw[2] = 1'b1;
        run_ticks(20);
        chk("long_once", cnt_long[2], 1);
        btn_raw = '0;
        run_ticks(5);

        // 5: release glitch on bit 3
        clear_counts();
        btn_raw[3] = 1'b1;
        run_ticks(4);
        btn_raw[3] = 1'b0;
        run_ticks(2);
        btn_raw[3] = 1'b1;
        run_ticks(1);
        chk("glitch_no_rel", cnt_rel[3], 0);
        chk("glitch_level", btn_level[3], 1);
        btn_raw[3] = 1'b0;
        run_ticks(3);
        chk("glitch_rel", cnt_rel[3], 1);
        chk("glitch_level_low", btn_level[3], 0);

        // 6: reset mid-press on bit 4
        clear_counts();
        btn_raw[4] = 1'b1;
        run_ticks(4);
        chk("pre_rst_level4", btn_level[4], 1);
        async_reset("midpress");
        chk("midpress_no_rel", cnt_rel[4], 0);
        btn_raw = '0;
        run_ticks(3);

        // Random activity: fast bouncing, then slower dwell to reach long presses.
        for (int c = 0; c < 6000; c++) begin
            for (int i = 0; i < NB; i++)
                if ($urandom_range(0, (c < 3000) ? 30 : 150) == 0) btn_raw[i] = ~btn_raw[i];
            step();
            if (c == 4500) async_reset("rand_rst");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
